pcs_receive: RTL and testbench

PCS_RECEIVE -- requirements
Module: pcs_receive

---
 rtl/pcs_receive.sv | 161 ++++++++++++++++
 tb/tb_pcs_receive.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive path: 8b/10b decode, code-group classification and the
// receive state machine that frames packets and tracks frame and error counts.
module pcs_receive (
  input  logic       clk,
  input  logic       mr_main_reset,
  input  logic [9:0] rx_code_group,
  output logic [7:0] RXD,
  output logic       RX_DV,
  output logic       RX_ER,
  output logic       sync_status,
  output logic [7:0] rx_pkt_count,
  output logic [7:0] rx_err_count
);

  typedef enum logic [2:0] {WAIT_FOR_K, RX_K, IDLE_D, RECEIVE, TRI_RRI} state_t;
  typedef enum logic [2:0] {C_K, C_S, C_T, C_R, C_D, C_INV} cls_t;

  state_t     r_state;
  logic [7:0] r_rxd;
  logic       r_rx_dv;
  logic       r_rx_er;
  logic       r_sync;
  logic [7:0] r_pkt_cnt;
  logic [7:0] r_err_cnt;

  cls_t       w_cls;
  logic [5:0] w_dec6;
  logic [3:0] w_dec4;
  logic [7:0] w_data;

  // Returns {valid, EDCBA}; both disparity columns accepted.
  function automatic logic [5:0] dec6(input logic [5:0] c);
    case (c)
      6'b100111, 6'b011000: dec6 = {1'b1, 5'd0};
      6'b011101, 6'b100010: dec6 = {1'b1, 5'd1};
      6'b101101, 6'b010010: dec6 = {1'b1, 5'd2};
      6'b110001:            dec6 = {1'b1, 5'd3};
      6'b110101, 6'b001010: dec6 = {1'b1, 5'd4};
      6'b101001:            dec6 = {1'b1, 5'd5};
      6'b011001:            dec6 = {1'b1, 5'd6};
      6'b111000, 6'b000111: dec6 = {1'b1, 5'd7};
      6'b111001, 6'b000110: dec6 = {1'b1, 5'd8};
      6'b100101:            dec6 = {1'b1, 5'd9};
      6'b010101:            dec6 = {1'b1, 5'd10};
      6'b110100:            dec6 = {1'b1, 5'd11};
      6'b001101:            dec6 = {1'b1, 5'd12};
      6'b101100:            dec6 = {1'b1, 5'd13};
      6'b011100:            dec6 = {1'b1, 5'd14};
      6'b010111, 6'b101000: dec6 = {1'b1, 5'd15};
      6'b011011, 6'b100100: dec6 = {1'b1, 5'd16};
      6'b100011:            dec6 = {1'b1, 5'd17};
      6'b010011:            dec6 = {1'b1, 5'd18};
      6'b110010:            dec6 = {1'b1, 5'd19};
      6'b001011:            dec6 = {1'b1, 5'd20};
      6'b101010:            dec6 = {1'b1, 5'd21};
      6'b011010:            dec6 = {1'b1, 5'd22};
      6'b111010, 6'b000101: dec6 = {1'b1, 5'd23};
      6'b110011, 6'b001100: dec6 = {1'b1, 5'd24};
      6'b100110:            dec6 = {1'b1, 5'd25};
      6'b010110:            dec6 = {1'b1, 5'd26};
      6'b110110, 6'b001001: dec6 = {1'b1, 5'd27};
      6'b001110:            dec6 = {1'b1, 5'd28};
      6'b101110, 6'b010001: dec6 = {1'b1, 5'd29};
      6'b011110, 6'b100001: dec6 = {1'b1, 5'd30};
      6'b101011, 6'b010100: dec6 = {1'b1, 5'd31};
      default:              dec6 = 6'b0;
    endcase
  endfunction

  // Returns {valid, HGF}; primary and alternate x.7 forms both map to 7.
  function automatic logic [3:0] dec4(input logic [3:0] c);
    case (c)
      4'b1011, 4'b0100:                   dec4 = {1'b1, 3'd0};
      4'b1001:                            dec4 = {1'b1, 3'd1};
      4'b0101:                            dec4 = {1'b1, 3'd2};
      4'b1100, 4'b0011:                   dec4 = {1'b1, 3'd3};
      4'b1101, 4'b0010:                   dec4 = {1'b1, 3'd4};
      4'b1010:                            dec4 = {1'b1, 3'd5};
      4'b0110:                            dec4 = {1'b1, 3'd6};
      4'b1110, 4'b0001, 4'b0111, 4'b1000: dec4 = {1'b1, 3'd7};
      default:                            dec4 = 4'b0;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // K23.7/K27.7/K29.7 alias D.x.A7 in a permissive decode, so specials win.
  always_comb begin
    w_dec6 = dec6(rx_code_group[9:4]);
    w_dec4 = dec4(rx_code_group[3:0]);
    w_data = {w_dec4[2:0], w_dec6[4:0]};
    w_cls  = C_INV;
    case (rx_code_group)
      10'b0011111010, 10'b1100000101: w_cls = C_K;
      10'b1101101000, 10'b0010010111: w_cls = C_S;
      10'b1011101000, 10'b0100010111: w_cls = C_T;
      10'b1110101000, 10'b0001010111: w_cls = C_R;
      default: if (w_dec6[5] && w_dec4[5-2]) w_cls = C_D;
    endcase
  end

  always_ff @(posedge clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      r_state   <= WAIT_FOR_K;
      r_rxd     <= 8'h00;
      r_rx_dv   <= 1'b0;
      r_rx_er   <= 1'b0;
      r_sync    <= 1'b0;
      r_pkt_cnt <= 8'h00;
      r_err_cnt <= 8'h00;
    end else begin
      r_rx_dv <= 1'b0;
      r_rx_er <= 1'b0;
      case (r_state)
        WAIT_FOR_K: if (w_cls == C_K) begin
          r_state <= RX_K;
          r_sync  <= 1'b1;
        end
        RX_K: if (w_cls == C_D) r_state <= IDLE_D;
              else begin r_state <= WAIT_FOR_K; r_sync <= 1'b0; end
        IDLE_D: case (w_cls)
          C_K: r_state <= RX_K;
          C_S: begin r_state <= RECEIVE; r_rxd <= 8'h55; r_rx_dv <= 1'b1; end
          default: begin r_state <= WAIT_FOR_K; r_sync <= 1'b0; end
        endcase
        RECEIVE: case (w_cls)
          C_D: begin r_rxd <= w_data; r_rx_dv <= 1'b1; end
          C_T: begin r_state <= TRI_RRI; r_pkt_cnt <= r_pkt_cnt + 8'd1; end
          C_K: begin
            r_state   <= RX_K;
            r_rx_dv   <= 1'b1;
            r_rx_er   <= 1'b1;
            r_err_cnt <= sat_inc(r_err_cnt);
          end
          default: begin
            r_rxd     <= 8'h00;
            r_rx_dv   <= 1'b1;
            r_rx_er   <= 1'b1;
            r_err_cnt <= sat_inc(r_err_cnt);
          end
        endcase
        TRI_RRI: case (w_cls)
          C_R: r_state <= TRI_RRI;
          C_K: r_state <= RX_K;
          default: begin r_state <= WAIT_FOR_K; r_sync <= 1'b0; end
        endcase
        default: begin r_state <= WAIT_FOR_K; r_sync <= 1'b0; end
      endcase
    end
  end

  assign RXD          = r_rxd;
  assign RX_DV        = r_rx_dv;
  assign RX_ER        = r_rx_er;
  assign sync_status  = r_sync;
  assign rx_pkt_count = r_pkt_cnt;
  assign rx_err_count = r_err_cnt;

endmodule

// File: tb/tb_pcs_receive.sv
// Directed bench for pcs_receive: a vector table walked cycle by cycle, plus
// hand-written sequences for async reset, counter wrap and error saturation.
module tb_pcs_receive;

  logic       clk = 1'b0;
  logic       mr_main_reset;
  logic [9:0] rx_code_group;
  logic [7:0] RXD;
  logic       RX_DV;
  logic       RX_ER;
  logic       sync_status;
  logic [7:0] rx_pkt_count;
  logic [7:0] rx_err_count;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [9:0] CG_KN  = 10'b0011111010;
  localparam logic [9:0] CG_KP  = 10'b1100000101;
  localparam logic [9:0] CG_SN  = 10'b1101101000;
  localparam logic [9:0] CG_SP  = 10'b0010010111;
  localparam logic [9:0] CG_TN  = 10'b1011101000;
  localparam logic [9:0] CG_TP  = 10'b0100010111;
  localparam logic [9:0] CG_RN  = 10'b1110101000;
  localparam logic [9:0] CG_RP  = 10'b0001010111;
  localparam logic [9:0] CG_D21 = 10'b1010101010;
  localparam logic [9:0] CG_D16 = 10'b1001001001;
  localparam logic [9:0] CG_A7  = 10'b1000110111;
  localparam logic [9:0] CG_K281= 10'b0011111001;
  localparam logic [9:0] CG_BAD = 10'b0000000000;

  pcs_receive dut (
    .clk           (clk),
    .mr_main_reset (mr_main_reset),
    .rx_code_group (rx_code_group),
    .RXD           (RXD),
    .RX_DV         (RX_DV),
    .RX_ER         (RX_ER),
    .sync_status   (sync_status),
    .rx_pkt_count  (rx_pkt_count),
    .rx_err_count  (rx_err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] code;
    logic       dv;
    logic       er;
    logic [7:0] rxd;
    logic       chk_rxd;
    logic       sync;
    logic [7:0] pkt;
    logic [7:0] err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [9:0] code, input logic dv, input logic er,
                     input logic [7:0] rxd, input logic chk_rxd, input logic sync,
                     input logic [7:0] pkt, input logic [7:0] err);
    vec_t v;
    v.code = code; v.dv = dv; v.er = er; v.rxd = rxd; v.chk_rxd = chk_rxd;
    v.sync = sync; v.pkt = pkt; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [9:0] code);
    rx_code_group = code;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mr_main_reset = 1'b0;
    rx_code_group = CG_BAD;
    repeat (2) @(posedge clk);
    #1;
    mr_main_reset = 1'b1;
  endtask

  initial begin
    mr_main_reset = 1'b0;
    rx_code_group = CG_BAD;

    // code           dv er rxd    c  sy pkt    err
    add(CG_D21,       0, 0, 8'h00, 1, 0, 8'd0, 8'd0);
    add(CG_D21,       0, 0, 8'h00, 1, 0, 8'd0, 8'd0);
    add(CG_D21,       0, 0, 8'h00, 1, 0, 8'd0, 8'd0);
    add(CG_D21,       0, 0, 8'h00, 1, 0, 8'd0, 8'd0);
    add(CG_KN,        0, 0, 8'h00, 1, 1, 8'd0, 8'd0);
    add(CG_D16,       0, 0, 8'h00, 1, 1, 8'd0, 8'd0);
    add(CG_SN,        1, 0, 8'h55, 1, 1, 8'd0, 8'd0);
    add(CG_D21,       1, 0, 8'hB5, 1, 1, 8'd0, 8'd0);
    add(CG_D21,       1, 0, 8'hB5, 1, 1, 8'd0, 8'd0);
    add(CG_D21,       1, 0, 8'hB5, 1, 1, 8'd0, 8'd0);
    add(CG_TN,        0, 0, 8'hB5, 1, 1, 8'd1, 8'd0);
    add(CG_RN,        0, 0, 8'hB5, 1, 1, 8'd1, 8'd0);
    add(CG_KN,        0, 0, 8'hB5, 1, 1, 8'd1, 8'd0);
    // errored frame: invalid group in place of second data octet
    add(CG_D16,       0, 0, 8'hB5, 1, 1, 8'd1, 8'd0);
    add(CG_SN,        1, 0, 8'h55, 1, 1, 8'd1, 8'd0);
    add(CG_D21,       1, 0, 8'hB5, 1, 1, 8'd1, 8'd0);
    add(CG_BAD,       1, 1, 8'h00, 1, 1, 8'd1, 8'd1);
    add(CG_D21,       1, 0, 8'hB5, 1, 1, 8'd1, 8'd1);
    add(CG_TN,        0, 0, 8'hB5, 1, 1, 8'd2, 8'd1);
    add(CG_KN,        0, 0, 8'hB5, 1, 1, 8'd2, 8'd1);
    // early end: /K/ in place of /T/, then D proves RX_K and /S/ proves IDLE_D
    add(CG_D16,       0, 0, 8'hB5, 1, 1, 8'd2, 8'd1);
    add(CG_SN,        1, 0, 8'h55, 1, 1, 8'd2, 8'd1);
    add(CG_D21,       1, 0, 8'hB5, 1, 1, 8'd2, 8'd1);
    add(CG_KN,        1, 1, 8'h00, 0, 1, 8'd2, 8'd2);
    add(CG_D16,       0, 0, 8'h00, 0, 1, 8'd2, 8'd2);
    add(CG_SN,        1, 0, 8'h55, 1, 1, 8'd2, 8'd2);
    add(CG_TN,        0, 0, 8'h55, 1, 1, 8'd3, 8'd2);
    add(CG_RN,        0, 0, 8'h55, 1, 1, 8'd3, 8'd2);
    add(CG_BAD,       0, 0, 8'h55, 1, 0, 8'd3, 8'd2);
    // RD+ specials, alternate D17.A7 decode, other error classes in RECEIVE
    add(CG_KP,        0, 0, 8'h55, 1, 1, 8'd3, 8'd2);
    add(CG_D21,       0, 0, 8'h55, 1, 1, 8'd3, 8'd2);
    add(CG_SP,        1, 0, 8'h55, 1, 1, 8'd3, 8'd2);
    add(CG_A7,        1, 0, 8'hF1, 1, 1, 8'd3, 8'd2);
    add(CG_K281,      1, 1, 8'h00, 1, 1, 8'd3, 8'd3);
    add(CG_RP,        1, 1, 8'h00, 1, 1, 8'd3, 8'd4);
    add(CG_SN,        1, 1, 8'h00, 1, 1, 8'd3, 8'd5);
    add(CG_D21,       1, 0, 8'hB5, 1, 1, 8'd3, 8'd5);
    add(CG_TP,        0, 0, 8'hB5, 1, 1, 8'd4, 8'd5);
    add(CG_KN,        0, 0, 8'hB5, 1, 1, 8'd4, 8'd5);
    add(CG_KN,        0, 0, 8'hB5, 1, 0, 8'd4, 8'd5);
    add(CG_D21,       0, 0, 8'hB5, 1, 0, 8'd4, 8'd5);

    do_reset();
    chk("rst_rxd",  RXD, 8'h00);
    chk("rst_dv",   {7'b0, RX_DV}, 8'h00);
    chk("rst_er",   {7'b0, RX_ER}, 8'h00);
    chk("rst_sync", {7'b0, sync_status}, 8'h00);
    chk("rst_pkt",  rx_pkt_count, 8'h00);
    chk("rst_err",  rx_err_count, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].code);
      chk($sformatf("v%0d_dv", i),   {7'b0, RX_DV}, {7'b0, vecs[i].dv});
      chk($sformatf("v%0d_er", i),   {7'b0, RX_ER}, {7'b0, vecs[i].er});
      chk($sformatf("v%0d_sync", i), {7'b0, sync_status}, {7'b0, vecs[i].sync});
      chk($sformatf("v%0d_pkt", i),  rx_pkt_count, vecs[i].pkt);
      chk($sformatf("v%0d_err", i),  rx_err_count, vecs[i].err);
      if (vecs[i].chk_rxd) chk($sformatf("v%0d_rxd", i), RXD, vecs[i].rxd);
    end

    // Asynchronous reset pulsed between edges in the middle of a frame
    step(CG_KN); step(CG_D16); step(CG_SN); step(CG_D21);
    chk("mid_dv_pre", {7'b0, RX_DV}, 8'h01);
    @(negedge clk);
    mr_main_reset = 1'b0;
    #1;
    chk("arst_dv",   {7'b0, RX_DV}, 8'h00);
    chk("arst_er",   {7'b0, RX_ER}, 8'h00);
    chk("arst_rxd",  RXD, 8'h00);
    chk("arst_sync", {7'b0, sync_status}, 8'h00);
    chk("arst_pkt",  rx_pkt_count, 8'h00);
    chk("arst_err",  rx_err_count, 8'h00);
    #1;
    mr_main_reset = 1'b1;
    step(CG_KN);
    chk("post_sync", {7'b0, sync_status}, 8'h01);
    step(CG_D16); step(CG_SN);
    chk("post_rxd55", RXD, 8'h55);
    step(CG_D21);
    chk("post_rxdB5", RXD, 8'hB5);
    chk("post_dv", {7'b0, RX_DV}, 8'h01);
    step(CG_TN);
    chk("post_pkt", rx_pkt_count, 8'h01);
    chk("post_dv_off", {7'b0, RX_DV}, 8'h00);

    // Frame counter wrap and error counter saturation
    do_reset();
    step(CG_KN); step(CG_D16);
    for (int f = 0; f < 255; f++) begin
      step(CG_SN); step(CG_TN); step(CG_KN); step(CG_D16);
    end
    chk("pkt_255", rx_pkt_count, 8'hFF);
    step(CG_SN); step(CG_TN);
    chk("pkt_wrap", rx_pkt_count, 8'h00);
    step(CG_KN); step(CG_D16); step(CG_SN);
    for (int e = 0; e < 300; e++) begin
      step(CG_BAD);
      if (e == 254) chk("err_255", rx_err_count, 8'hFF);
    end
    chk("err_sat", rx_err_count, 8'hFF);
    chk("err_sat_er", {7'b0, RX_ER}, 8'h01);
    chk("err_sat_rxd", RXD, 8'h00);
    chk("err_sat_pkt", rx_pkt_count, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
